// File: rtl/idecode_pipe.sv
// RV32/RV64 decode stage: {instr, pc} in, registered decoded entry out, optional M and W ops.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: 2-entry skid (output + skid register); in_ready drops only while the skid is full.
module idecode_pipe #(
    parameter int XLEN     = 64,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alu_op,
    output logic [11:0]     out_csr_addr,
    output logic [9:0]      out_ctrl,
    output logic            out_trap,
    output logic [3:0]      out_trap_cause
);

    typedef enum logic [4:0] {
        ALU_NONE = 5'd0,  ALU_ADD  = 5'd1,  ALU_SUB  = 5'd2,  ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,  ALU_XOR  = 5'd5,  ALU_SLL  = 5'd6,  ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,  ALU_SLT  = 5'd9,  ALU_SLTU = 5'd10, ALU_MUL  = 5'd11
    } alu_op_t;

    typedef struct packed {
        logic is_w;
        logic is_csr;
        logic csr_read;
        logic csr_write;
        logic use_pc;
        logic jump;
        logic is_branch;
        logic mem_write;
        logic mem_read;
        logic reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        alu_op_t         alu_op;
        logic [11:0]     csr_addr;
        ctrl_t           ctrl;
        logic            trap;
        logic [3:0]      cause;
    } dec_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    function automatic alu_op_t base_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    // MUL..REMU are contiguous codes in funct3 order
    function automatic alu_op_t m_op(input logic [2:0] f3);
        m_op = alu_op_t'(5'd11 + {2'b00, f3});
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt6, shamt5;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign i_imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign s_imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign b_imm  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign u_imm  = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
    assign j_imm  = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign shamt6 = {{(XLEN-6){1'b0}}, in_instr[25:20]};
    assign shamt5 = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    logic    illegal, is_ecall, is_ebreak;
    ctrl_t   ctrl;
    alu_op_t alu;
    logic [XLEN-1:0] imm;
    dec_t    dec;

    always_comb begin
        illegal   = 1'b0;
        is_ecall  = 1'b0;
        is_ebreak = 1'b0;
        ctrl      = '0;
        alu       = ALU_NONE;
        imm       = '0;
        case (opcode)
            OPC_LUI: begin
                imm = u_imm;
                ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm = u_imm;
                alu = ALU_ADD;
                ctrl.use_pc = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_JAL: begin
                imm = j_imm;
                alu = ALU_ADD;
                ctrl.use_pc = 1'b1;
                ctrl.jump = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_JALR: begin
                imm = i_imm;
                alu = ALU_ADD;
                ctrl.jump = 1'b1;
                ctrl.reg_write = 1'b1;
                illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm = b_imm;
                ctrl.is_branch = 1'b1;
                illegal = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                imm = i_imm;
                alu = ALU_ADD;
                ctrl.mem_read = 1'b1;
                ctrl.reg_write = 1'b1;
                illegal = (f3 == 3'b111) || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OPC_STORE: begin
                imm = s_imm;
                alu = ALU_ADD;
                ctrl.mem_write = 1'b1;
                illegal = f3[2] || (XLEN == 32 && f3 == 3'b011);
            end
            OPC_OP_IMM: begin
                imm = i_imm;
                alu = base_op(f3, 1'b0);
                ctrl.reg_write = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    imm = shamt6;
                    if (f3 == 3'b101 && in_instr[31:26] == 6'b010000)
                        alu = ALU_SRA;
                    else if (in_instr[31:26] != 6'b000000)
                        illegal = 1'b1;
                    if (XLEN == 32 && in_instr[25])
                        illegal = 1'b1;
                end
            end
            OPC_OP_IMM32: begin
                imm = i_imm;
                alu = base_op(f3, 1'b0);
                ctrl.is_w = 1'b1;
                ctrl.reg_write = 1'b1;
                case (f3)
                    3'b000: ;
                    3'b001: begin
                        imm = shamt5;
                        illegal = (f7 != F7_BASE);
                    end
                    3'b101: begin
                        imm = shamt5;
                        if (f7 == F7_ALT) alu = ALU_SRA;
                        else illegal = (f7 != F7_BASE);
                    end
                    default: illegal = 1'b1;
                endcase
                if (XLEN == 32) illegal = 1'b1;
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                if (f7 == F7_BASE)
                    alu = base_op(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
                    alu = base_op(f3, 1'b1);
                else if (f7 == F7_M && ENABLE_M)
                    alu = m_op(f3);
                else
                    illegal = 1'b1;
            end
            OPC_OP32: begin
                ctrl.is_w = 1'b1;
                ctrl.reg_write = 1'b1;
                // only ADD/SUB/SLL/SRL/SRA and MUL/DIV*/REM* have W forms
                if (f7 == F7_BASE && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101))
                    alu = base_op(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
                    alu = base_op(f3, 1'b1);
                else if (f7 == F7_M && ENABLE_M && (f3 == 3'b000 || f3[2]))
                    alu = m_op(f3);
                else
                    illegal = 1'b1;
                if (XLEN == 32) illegal = 1'b1;
            end
            OPC_SYSTEM: begin
                imm = i_imm;
                if (f3 == 3'b000) begin
                    if (in_instr == 32'h0000_0073)      is_ecall  = 1'b1;
                    else if (in_instr == 32'h0010_0073) is_ebreak = 1'b1;
                    else                                illegal   = 1'b1;
                end else if (f3 == 3'b100) begin
                    illegal = 1'b1;
                end else begin
                    ctrl.is_csr = 1'b1;
                    ctrl.reg_write = 1'b1;
                    if (f3[1:0] == 2'b01) begin
                        ctrl.csr_write = 1'b1;
                        ctrl.csr_read  = (in_instr[11:7] != 5'd0);
                    end else begin
                        ctrl.csr_read  = 1'b1;
                        ctrl.csr_write = (in_instr[19:15] != 5'd0);
                    end
                end
            end
            default: illegal = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) illegal = 1'b1;

        dec.pc       = in_pc;
        dec.rd       = in_instr[11:7];
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.funct3   = f3;
        dec.imm      = imm;
        dec.csr_addr = in_instr[31:20];
        dec.trap     = illegal | is_ecall | is_ebreak;
        dec.cause    = illegal ? 4'd2 : is_ecall ? 4'd11 : is_ebreak ? 4'd3 : 4'd0;
        dec.alu_op   = dec.trap ? ALU_NONE : alu;
        dec.ctrl     = dec.trap ? ctrl_t'('0) : ctrl;
    end

    dec_t out_q, skid_q;
    logic out_vld_q, skid_vld_q;
    logic accept;

    assign in_ready = !skid_vld_q && !reset;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (out_vld_q && out_ready) begin
            // in_ready is low whenever the skid holds an entry, so no accept competes here
            if (skid_vld_q) begin
                out_q      <= skid_q;
                skid_vld_q <= 1'b0;
            end else if (accept) begin
                out_q <= dec;
            end else begin
                out_vld_q <= 1'b0;
            end
        end else if (!out_vld_q) begin
            if (accept) begin
                out_q     <= dec;
                out_vld_q <= 1'b1;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_vld_q <= 1'b1;
        end
    end

    assign out_valid      = out_vld_q;
    assign out_pc         = out_q.pc;
    assign out_rd         = out_q.rd;
    assign out_rs1        = out_q.rs1;
    assign out_rs2        = out_q.rs2;
    assign out_funct3     = out_q.funct3;
    assign out_imm        = out_q.imm;
    assign out_alu_op     = out_q.alu_op;
    assign out_csr_addr   = out_q.csr_addr;
    assign out_ctrl       = out_q.ctrl;
    assign out_trap       = out_q.trap;
    assign out_trap_cause = out_q.cause;

endmodule
